// File: rtl/board_pkg.sv
// Shared board geometry, FSM state type and cell index type for the mouse-to-cell picker.
package board_pkg;

  localparam int unsigned SCREEN_WIDTH   = 1024;
  localparam int unsigned SCREEN_HEIGHT  = 768;
  localparam int unsigned CELL_SIZE      = 16;
  localparam int unsigned MAX_BOARD_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } pick_state_t;

  typedef logic [3:0] cell_idx_t;

  // Left/top pixel of a centred board of pixel width w on a screen axis of size extent.
  function automatic logic [12:0] board_origin(input logic [12:0] extent, input logic [12:0] w);
    logic [12:0] diff;
    diff = extent - w;
    return diff >> 1;
  endfunction

endpackage

// File: rtl/board_cell_map.sv
// Combinational pixel-to-cell mapper for the centred board; grid-line pixels are misses.
module board_cell_map
  import board_pkg::*;
(
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [2:0]  board_size,
  output logic        hit,
  output logic [3:0]  row,
  output logic [3:0]  col
);

  logic               legal;
  logic [5:0]         side;
  logic [12:0]        w;
  logic [12:0]        x0;
  logic [12:0]        y0;
  logic signed [12:0] ox;
  logic signed [12:0] oy;
  logic               in_x;
  logic               in_y;

  always_comb begin
    legal = (board_size != 3'd0) && (32'(board_size) <= MAX_BOARD_SIZE);
    side  = {3'b000, board_size} * {3'b000, board_size};
    w     = 13'(side) * 13'(CELL_SIZE);
    x0    = board_origin(13'(SCREEN_WIDTH), w);
    y0    = board_origin(13'(SCREEN_HEIGHT), w);
    ox    = $signed({1'b0, x}) - $signed(x0);
    oy    = $signed({1'b0, y}) - $signed(y0);
    // Strictly inside the board and off the vertical/horizontal grid lines.
    in_x  = (ox > 13'sd0) && (ox < $signed(w)) && (ox[3:0] != 4'd0);
    in_y  = (oy > 13'sd0) && (oy < $signed(w)) && (oy[3:0] != 4'd0);
    hit   = legal && in_x && in_y;
    col   = ox[7:4];
    row   = oy[7:4];
  end

endmodule

// File: rtl/board_cell_picker.sv
// Converts left-button clicks into board (row, col) picks on a valid/ready output.
// Define BOARD_PICK_HOVER_EN to drive the registered hover outputs from the live pointer.
module board_cell_picker
  import board_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_game_on,
  input  logic [2:0]       board_size,
  input  logic [11:0]      mouse_x,
  input  logic [11:0]      mouse_y,
  input  logic             mouse_left,
  input  logic             pick_ready,
  output logic             pick_valid,
  output logic [3:0]       pick_row,
  output logic [3:0]       pick_col,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             hover_valid,
  output logic [3:0]       hover_row,
  output logic [3:0]       hover_col
);

  pick_state_t state_q;
  logic        prev_left_q;
  logic [11:0] cap_x_q;
  logic [11:0] cap_y_q;
  logic [2:0]  cap_size_q;

  logic        click;
  logic        map_hit;
  cell_idx_t   map_row;
  cell_idx_t   map_col;

  assign click = mouse_left & ~prev_left_q;

  board_cell_map u_click_map (
    .x          (cap_x_q),
    .y          (cap_y_q),
    .board_size (cap_size_q),
    .hit        (map_hit),
    .row        (map_row),
    .col        (map_col)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_left_q <= 1'b0;
      cap_x_q     <= '0;
      cap_y_q     <= '0;
      cap_size_q  <= '0;
      pick_valid  <= 1'b0;
      pick_row    <= '0;
      pick_col    <= '0;
      miss_cnt    <= '0;
      drop_cnt    <= '0;
    end else begin
      prev_left_q <= mouse_left;
      unique case (state_q)
        IDLE: begin
          if (click && is_game_on) begin
            cap_x_q    <= mouse_x;
            cap_y_q    <= mouse_y;
            cap_size_q <= board_size;
            state_q    <= CALC;
          end
        end
        CALC: begin
          if (!is_game_on) begin
            state_q    <= IDLE;
            pick_valid <= 1'b0;
          end else if (map_hit) begin
            pick_row   <= map_row;
            pick_col   <= map_col;
            pick_valid <= 1'b1;
            state_q    <= HOLD;
          end else begin
            if (miss_cnt != {CNT_W{1'b1}}) begin
              miss_cnt <= miss_cnt + 1'b1;
            end
            state_q <= IDLE;
          end
        end
        HOLD: begin
          // Abort and handshake both retire the pick; only the handshake is a delivery.
          if (!is_game_on || pick_ready) begin
            pick_valid <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          pick_valid <= 1'b0;
          state_q    <= IDLE;
        end
      endcase

      // Clicks arriving while a pick is in flight are lost, including the handshake cycle.
      if (click && is_game_on && (state_q != IDLE) && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

`ifdef BOARD_PICK_HOVER_EN
  logic      hov_hit;
  cell_idx_t hov_row;
  cell_idx_t hov_col;

  board_cell_map u_hover_map (
    .x          (mouse_x),
    .y          (mouse_y),
    .board_size (board_size),
    .hit        (hov_hit),
    .row        (hov_row),
    .col        (hov_col)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hover_valid <= 1'b0;
      hover_row   <= '0;
      hover_col   <= '0;
    end else begin
      hover_valid <= is_game_on & hov_hit;
      hover_row   <= is_game_on ? hov_row : 4'd0;
      hover_col   <= is_game_on ? hov_col : 4'd0;
    end
  end
`else
  assign hover_valid = 1'b0;
  assign hover_row   = 4'd0;
  assign hover_col   = 4'd0;
`endif

endmodule

// File: tb/tb_board_cell_picker.sv
// Directed bench for board_cell_picker: expected picks are queued and checked at handshake.
module tb_board_cell_picker;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_game_on;
  logic [2:0]  board_size;
  logic [11:0] mouse_x;
  logic [11:0] mouse_y;
  logic        mouse_left;
  logic        pick_ready;
  logic        pick_valid;
  logic [3:0]  pick_row;
  logic [3:0]  pick_col;
  logic [7:0]  miss_cnt;
  logic [7:0]  drop_cnt;
  logic        hover_valid;
  logic [3:0]  hover_row;
  logic [3:0]  hover_col;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  board_cell_picker #(.CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .is_game_on  (is_game_on),
    .board_size  (board_size),
    .mouse_x     (mouse_x),
    .mouse_y     (mouse_y),
    .mouse_left  (mouse_left),
    .pick_ready  (pick_ready),
    .pick_valid  (pick_valid),
    .pick_row    (pick_row),
    .pick_col    (pick_col),
    .miss_cnt    (miss_cnt),
    .drop_cnt    (drop_cnt),
    .hover_valid (hover_valid),
    .hover_row   (hover_row),
    .hover_col   (hover_col)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic click(input int x, input int y);
    mouse_x    = 12'(x);
    mouse_y    = 12'(y);
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
    tick();
  endtask

  // Monitor: every accepted pick must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && pick_valid && pick_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pick_unexpected: got row %0d col %0d expected no pick", pick_row, pick_col);
      end else begin
        mon_exp = exp_q.pop_front();
        pops++;
        if ({pick_row, pick_col} !== mon_exp) begin
          errors++;
          $display("FAIL pick_data: got row %0d col %0d expected row %0d col %0d",
                   pick_row, pick_col, mon_exp[7:4], mon_exp[3:0]);
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    is_game_on = 1'b0;
    board_size = 3'd3;
    mouse_x    = '0;
    mouse_y    = '0;
    mouse_left = 1'b0;
    pick_ready = 1'b0;
    tick();
    tick();
    chk("reset_valid", 32'(pick_valid), 0);
    chk("reset_row", 32'(pick_row), 0);
    chk("reset_col", 32'(pick_col), 0);
    chk("reset_miss", 32'(miss_cnt), 0);
    chk("reset_drop", 32'(drop_cnt), 0);
    chk("reset_hover", 32'({hover_valid, hover_row, hover_col}), 0);
    rst        = 1'b0;
    is_game_on = 1'b1;
    pick_ready = 1'b1;
    tick();

    // Basic hit, N=3: ox=37, oy=72 -> row 4, col 2.
    exp_q.push_back({4'd4, 4'd2});
    mouse_x    = 12'd477;
    mouse_y    = 12'd384;
    mouse_left = 1'b1;
    tick();
    chk("hit_valid_early", 32'(pick_valid), 0);
    mouse_left = 1'b0;
    tick();
    chk("hit_latency", 32'(pick_valid), 1);
    chk("hit_row", 32'(pick_row), 4);
    chk("hit_col", 32'(pick_col), 2);
    tick();
    chk("hit_one_cycle", 32'(pick_valid), 0);

    // Grid line (ox=16) and board edge (ox=0) are misses.
    click(456, 384);
    chk("grid_valid", 32'(pick_valid), 0);
    chk("grid_miss", 32'(miss_cnt), 1);
    click(440, 384);
    chk("edge_miss", 32'(miss_cnt), 2);

    // Corners, N=4.
    board_size = 3'd4;
    exp_q.push_back({4'd15, 4'd15});
    click(639, 511);
    chk("corner_valid", 32'(pick_valid), 1);
    tick();
    click(640, 511);
    chk("corner_out_miss", 32'(miss_cnt), 3);
    chk("corner_out_valid", 32'(pick_valid), 0);

    // Backpressure, N=2: ox=9, oy=9 -> row 0, col 0.
    board_size = 3'd2;
    pick_ready = 1'b0;
    exp_q.push_back({4'd0, 4'd0});
    click(489, 361);
    chk("bp_valid", 32'(pick_valid), 1);
    board_size = 3'd4;
    click(0, 0);
    click(0, 0);
    repeat (6) tick();
    chk("bp_hold_valid", 32'(pick_valid), 1);
    chk("bp_hold_data", 32'({pick_row, pick_col}), 0);
    chk("bp_drop", 32'(drop_cnt), 2);
    chk("bp_miss", 32'(miss_cnt), 3);
    pick_ready = 1'b1;
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
    chk("bp_release", 32'(pick_valid), 0);
    chk("handshake_click_drop", 32'(drop_cnt), 3);
    tick();
    tick();
    chk("handshake_click_ignored", 32'(pick_valid), 0);
    chk("handshake_click_nomiss", 32'(miss_cnt), 3);

    // Abort during HOLD; clicks while off are ignored.
    board_size = 3'd3;
    pick_ready = 1'b0;
    click(477, 384);
    chk("abort_hold", 32'(pick_valid), 1);
    is_game_on = 1'b0;
    tick();
    chk("abort_valid", 32'(pick_valid), 0);
    click(477, 384);
    click(0, 0);
    chk("off_valid", 32'(pick_valid), 0);
    chk("off_miss", 32'(miss_cnt), 3);
    chk("off_drop", 32'(drop_cnt), 3);
    is_game_on = 1'b1;
    tick();

    // Reset during HOLD.
    click(477, 384);
    chk("rst_hold_valid", 32'(pick_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", 32'(pick_valid), 0);
    chk("rst_mid_data", 32'({pick_row, pick_col}), 0);
    chk("rst_mid_miss", 32'(miss_cnt), 0);
    chk("rst_mid_drop", 32'(drop_cnt), 0);
    tick();

    // Miss counter saturation.
    pick_ready = 1'b1;
    for (int i = 0; i < 300; i++) click(0, 0);
    chk("sat_miss", 32'(miss_cnt), 255);
    chk("sat_drop", 32'(drop_cnt), 0);

    // Held button gives a single event.
    exp_q.push_back({4'd4, 4'd2});
    mouse_x    = 12'd477;
    mouse_y    = 12'd384;
    mouse_left = 1'b1;
    repeat (50) tick();
    mouse_left = 1'b0;
    tick();
    tick();
    chk("held_drop", 32'(drop_cnt), 0);
    chk("held_valid", 32'(pick_valid), 0);

    // Hover outputs.
    board_size = 3'd3;
    mouse_x    = 12'd477;
    mouse_y    = 12'd384;
    tick();
`ifdef BOARD_PICK_HOVER_EN
    chk("hover_hit", 32'({hover_valid, hover_row, hover_col}), 32'({1'b1, 4'd4, 4'd2}));
`else
    chk("hover_tied", 32'({hover_valid, hover_row, hover_col}), 0);
`endif

    chk("pick_count", 32'(pops), 4);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
